// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch and data access,
// data first, with a streak limit so that fetch is not starved.
module mem_port_arbiter #(
    parameter int DSTREAK = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        mem_req,
    output logic        mem_we,
    output logic [2:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        stall_if,
    output logic        stall_d
);
    typedef enum logic [1:0] {IDLE, GNT_IF, GNT_D} state_t;

    localparam logic [3:0] STREAK_MAX = 4'(DSTREAK);

    state_t     state, nextState;
    logic       ifReqM, dReqM, grantD, grantIf;
    logic [3:0] streak;

    // A port is ignored in its own completion cycle so that its held req is not re-granted.
    assign ifReqM   = if_req & ~if_valid;
    assign dReqM    = d_req & ~d_valid;
    assign stall_if = if_req & ~if_valid;
    assign stall_d  = d_req & ~d_valid;

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= nextState;

    always_comb begin
        nextState = state;
        grantD    = 1'b0;
        grantIf   = 1'b0;
        case (state)
            IDLE: begin
                grantD    = dReqM & (~ifReqM | (streak != STREAK_MAX));
                grantIf   = ifReqM & ~grantD;
                nextState = grantD ? GNT_D : grantIf ? GNT_IF : IDLE;
            end
            GNT_IF:  nextState = mem_ready ? IDLE : GNT_IF;
            GNT_D:   nextState = mem_ready ? IDLE : GNT_D;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_size  <= 3'b000;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            if_rdata  <= 32'h0;
            d_rdata   <= 32'h0;
            if_valid  <= 1'b0;
            d_valid   <= 1'b0;
            streak    <= 4'h0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            if (grantD) begin
                mem_req   <= 1'b1;
                mem_we    <= d_we;
                mem_size  <= d_size;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                if (ifReqM && streak != STREAK_MAX) streak <= streak + 4'h1;
            end else if (grantIf) begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_size <= 3'b010;
                mem_addr <= if_addr;
                streak   <= 4'h0;
            end
            if (state == GNT_IF && mem_ready) begin
                mem_req  <= 1'b0;
                if_valid <= 1'b1;
                if_rdata <= mem_rdata;
            end
            if (state == GNT_D && mem_ready) begin
                mem_req <= 1'b0;
                d_valid <= 1'b1;
                d_rdata <= mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, latency, streak limit, holding and reset.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we, mem_ready;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [2:0]  d_size;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_valid, d_valid, mem_req, mem_we, stall_if, stall_d;
    logic [2:0]  mem_size;
    int          checks = 0;
    int          failures = 0;

    mem_port_arbiter #(.DSTREAK(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_d(stall_d)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        chk("valid_onehot", {31'b0, if_valid & d_valid}, 32'h0);
    endtask

    initial begin
        logic expD [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int   grants;
        logic prevReq;
        reset = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
        if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; mem_rdata = 32'h0; d_size = 3'b000;
        step();
        step();
        chk("reset_cmd", {31'b0, mem_req | mem_we} | mem_addr | mem_wdata | {29'b0, mem_size}, 32'h0);
        chk("reset_out", {30'b0, if_valid, d_valid} | if_rdata | d_rdata, 32'h0);
        reset = 1'b1;

        // Single fetch, memory ready at once
        if_req = 1'b1; if_addr = 32'h100; mem_ready = 1'b1; mem_rdata = 32'h00500093;
        step();
        chk("t1_req", {30'b0, mem_req, mem_we}, 32'h2);
        chk("t1_addr", mem_addr, 32'h100);
        chk("t1_size", {29'b0, mem_size}, 32'h2);
        chk("t1_stall_busy", {31'b0, stall_if}, 32'h1);
        step();
        chk("t1_valid", {30'b0, if_valid, mem_req}, 32'h2);
        chk("t1_rdata", if_rdata, 32'h00500093);
        chk("t1_stall_done", {31'b0, stall_if}, 32'h0);
        if_req = 1'b0;
        step();
        chk("t1_pulse", {31'b0, if_valid}, 32'h0);

        // Simultaneous store and fetch: data first, fetch right after
        if_req = 1'b1; if_addr = 32'h104;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_size = 3'b010;
        step();
        chk("t2_dreq", {30'b0, mem_req, mem_we}, 32'h3);
        chk("t2_daddr", mem_addr, 32'h2000);
        chk("t2_dwdata", mem_wdata, 32'hDEADBEEF);
        chk("t2_dsize", {29'b0, mem_size}, 32'h2);
        step();
        chk("t2_dvalid", {30'b0, d_valid, mem_req}, 32'h2);
        d_req = 1'b0;
        step();
        chk("t2_ifreq", {30'b0, mem_req, mem_we}, 32'h2);
        chk("t2_ifaddr", mem_addr, 32'h104);
        step();
        chk("t2_ifvalid", {31'b0, if_valid}, 32'h1);
        if_req = 1'b0;
        step();

        // Streak limit: data always pending, fetch pending except in data completion cycles
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; if_addr = 32'h400; mem_ready = 1'b1;
        grants = 0;
        prevReq = mem_req;
        for (int c = 0; c < 80 && grants < 11; c++) begin
            if_req = ~d_valid;
            step();
            if (mem_req && !prevReq) begin
                chk($sformatf("t3_grant%0d", grants), mem_addr, expD[grants] ? 32'h3000 : 32'h400);
                grants++;
            end
            prevReq = mem_req;
        end
        chk("t3_grant_count", grants, 32'd11);
        d_req = 1'b0;
        step();
        if_req = 1'b0;
        step();

        // Slow memory: command held, input changes ignored, single late valid
        mem_ready = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h5000; d_wdata = 32'hCAFEF00D; d_size = 3'b001;
        step();
        d_addr = 32'h6666; d_wdata = 32'h0;
        for (int c = 1; c <= 6; c++) begin
            chk($sformatf("t4_hold%0d", c), {mem_req, mem_we, d_valid, stall_d, 28'h0} ^ mem_addr ^ mem_wdata,
                32'hD000_0000 ^ 32'h5000 ^ 32'hCAFEF00D);
            if (c == 6) mem_ready = 1'b1;
            else step();
        end
        step();
        chk("t4_valid", {30'b0, d_valid, mem_req}, 32'h2);
        chk("t4_size_kept", {29'b0, mem_size}, 32'h1);
        d_req = 1'b0; mem_ready = 1'b0;
        step();
        chk("t4_pulse", {31'b0, d_valid}, 32'h0);

        // Load data held through a later fetch completion
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h7000; mem_ready = 1'b1; mem_rdata = 32'h12345678;
        step();
        chk("t6_load_req", {30'b0, mem_req, mem_we}, 32'h2);
        step();
        chk("t6_dvalid", {31'b0, d_valid}, 32'h1);
        chk("t6_drdata", d_rdata, 32'h12345678);
        d_req = 1'b0; if_req = 1'b1; if_addr = 32'h108; mem_rdata = 32'hAAAA5555;
        step();
        chk("t6_ifaddr", mem_addr, 32'h108);
        step();
        chk("t6_ifrdata", if_rdata, 32'hAAAA5555);
        chk("t6_drdata_held", d_rdata, 32'h12345678);
        if_req = 1'b0;
        step();

        // Reset in the middle of a data access
        mem_ready = 1'b0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h9000; d_wdata = 32'h11112222;
        step();
        chk("t5_busy", {30'b0, mem_req, mem_we}, 32'h3);
        reset = 1'b0;
        #1;
        chk("t5_cmd_zero", {31'b0, mem_req | mem_we} | mem_addr | mem_wdata | {29'b0, mem_size}, 32'h0);
        chk("t5_out_zero", {30'b0, if_valid, d_valid} | if_rdata | d_rdata, 32'h0);
        d_req = 1'b0; mem_ready = 1'b1;
        step();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("t5_quiet%0d", c), {29'b0, d_valid, mem_req, stall_d}, 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
